flappy_game_engine: RTL
=======================

// Module: flappy_game_engine
// PURPOSE
//  Game-state engine directly upstream of vga640x480. Owns the bird, pillar and score state
//  and feeds it to the renderer, which only draws. Runs an IDLE/PLAY/DEAD state machine.
//  Advances physics once per tick from a dclk divider, randomises the pillar gap with an LFSR,
//  and detects collisions.
// PARAMETERS
//  TICK_DIV   200000  dclk cycles per physics tick
//  BIRD_X     240     bird left edge, screen px (fixed)
//  BIRD_SZ    20      bird width/height, px
//  PILLAR_W   40      pillar width, px
//  GAP_H      120     vertical opening height, px
//  GAP_MIN    40      gap_y offset added to LFSR value
//  FLAP_UP    6       px moved up per tick while flap held
//  FALL_DN    4       px moved down per tick otherwise
//  Y_MIN      10      no upward move when bird_y <= Y_MIN
//  Y_FLOOR    455     bird_y >= Y_FLOOR in PLAY -> DEAD
// PORTS
//  dclk       in   1   25 MHz pixel clock; sole clock
//  clr        in   1   reset, synchronous, active-high
//  flap       in   1   debounced flap button, level
//  pause      in   1   level; freezes tick divider and all game state
//  bird_y     out  10  bird top edge, px from top of active area
//  pillar_x   out  12  pillar left edge, px; 640 = fully off-screen right
//  gap_y      out  10  top of pillar opening, px
//  score      out  8   pillars passed, saturating
//  gamestate  out  1   1 in PLAY or DEAD, 0 in IDLE (renderer's existing input)
//  game_over  out  1   1 in DEAD
// BEHAVIOUR
//  - Reset (clr=1 at posedge dclk) forces on that edge: state=IDLE, bird_y=240, pillar_x=640,
//    gap_y=GAP_MIN+8'hA5, score=0, gamestate=0, game_over=0, tick cnt=0, lfsr=8'hA5,
//    flap_q=0. Applies from any state, mid-tick included.
//  - All outputs are registered. Values computed on a tick edge are visible the next cycle.
//  - tick: cnt counts 0..TICK_DIV-1 and wraps. tick=1 when cnt==TICK_DIV-1 and pause=0.
//    cnt holds while pause=1.
//  - flap_rise = flap & ~flap_q. flap_q samples flap every cycle, including while paused.
//  - lfsr: 8-bit Fibonacci, taps 8,6,5,4. Steps every non-reset cycle. Never reaches 0.
//  - IDLE: bird_y=240, pillar_x=640, score=0.
//    flap_rise & ~pause -> PLAY on the next edge, not waiting for a tick.
//  - PLAY, on tick only:
//      bird_y: if flap & bird_y>Y_MIN, bird_y-FLAP_UP; else bird_y+FALL_DN.
//      pillar_x: if 0, reload 640 and gap_y<=GAP_MIN+lfsr; else pillar_x-1.
//      score: +1 (saturate 255) when the pre-update pillar_x+PILLAR_W == BIRD_X.
//  - Collision, evaluated on tick using pre-update values; hit -> DEAD:
//      x_ov = pillar_x < BIRD_X+BIRD_SZ && pillar_x+PILLAR_W > BIRD_X
//      y_out = bird_y < gap_y || bird_y+BIRD_SZ > gap_y+GAP_H
//      hit = (x_ov & y_out) | (bird_y >= Y_FLOOR)
//  - A hit on a tick blocks every update on that tick: bird_y, pillar_x and score are frozen
//    at their pre-tick values, with no score increment. Collision wins over score.
//  - DEAD: all positions and score held. flap_rise & ~pause -> IDLE, which restores the
//    IDLE values on that edge. A flap still held from PLAY does not count: a new rising edge
//    is required.
//  - pause=1: no state transition and no update of bird_y, pillar_x, gap_y or score.
//  - Widths: compare in 12-bit unsigned. Minimum gap_y is 40 and bird_y>=Y_MIN=10 on flap,
//    so the (bird_y - 6) and compare results cannot underflow.
//    Max gap_y+GAP_H = 40+255+120 = 415 < 480.
// STRUCTURE
//  - Shared package flappy_pkg: state enum (IDLE=2'd0, PLAY=2'd1, DEAD=2'd2), SCREEN_W=640,
//    SCREEN_H=480, BIRD_X, BIRD_SZ, PILLAR_W, GAP_H. vga640x480 imports the same constants.
//  - One sub-module: flappy_tick_gen (TICK_DIV counter with pause hold; outputs tick).
//  - LFSR, edge detect, FSM and collision logic stay inline.
// TESTING (bench uses TICK_DIV=4)
//  1. clr for 2 cycles, then idle 20 cycles -> bird_y=240, pillar_x=640, score=0,
//     gamestate=0, no movement.
//  2. flap pulsed 1 cycle in IDLE -> gamestate=1 next cycle; after 3 ticks with flap=0,
//     bird_y=252 and pillar_x=637.
//  3. PLAY, flap held 5 ticks from bird_y=240 -> 210; hold until bird_y<=10 -> bird_y stops
//     decreasing and instead falls 4/tick.
//  4. Force a gap aligned with the bird, run pillar from 280 down to 199 -> score 0->1 exactly
//     on the tick leaving pillar_x=199.
//  5. Misaligned gap (bird_y=240, gap_y=40), pillar reaches 259 -> DEAD; bird_y, pillar_x and
//     score frozen. Flap still held -> stays DEAD; release then press -> IDLE.
//  6. pause=1 for 50 cycles mid-PLAY -> all outputs constant, tick count resumes from held
//     value. clr pulse mid-tick -> full reset values next cycle.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared game constants and types for the flappy engine and the vga640x480 renderer.
// Also holds the pillar-gap LFSR step so every user agrees on the sequence.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DEAD = 2'd2
   } game_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int BIRD_X   = 240;
   localparam int BIRD_SZ  = 20;
   localparam int PILLAR_W = 40;
   localparam int GAP_H    = 120;

   // 8-bit Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero from a nonzero seed)
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

endpackage

// File: rtl/flappy_game_engine_if.sv
// Player inputs and game-state outputs of the flappy engine, bundled for the engine
// (slave side) and whoever drives the controls and reads the state (master side).
interface flappy_game_engine_if;

   logic        flap;
   logic        pause;
   logic [9:0]  bird_y;
   logic [11:0] pillar_x;
   logic [9:0]  gap_y;
   logic [7:0]  score;
   logic        gamestate;
   logic        game_over;

   modport master (
      output flap, pause,
      input  bird_y, pillar_x, gap_y, score, gamestate, game_over
   );

   modport slave (
      input  flap, pause,
      output bird_y, pillar_x, gap_y, score, gamestate, game_over
   );

endinterface

// File: rtl/flappy_tick_gen.sv
// Physics tick divider: counts 0..TICK_DIV-1 on dclk, pulses tick on the last count,
// and freezes completely (count held, no tick) while pause is high.
module flappy_tick_gen #(
   parameter int TICK_DIV = 200000
) (
   input  logic clk,
   input  logic clr,
   input  logic pause,
   output logic tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             at_last_s;

   assign at_last_s = (cnt_r == CNT_LAST);
   assign tick      = at_last_s & ~pause;

   // Divider counter: reset to zero, hold while paused, wrap after the last count
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (pause) begin
         cnt_r <= cnt_r;
      end else if (at_last_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/flappy_game_engine.sv
// Flappy game-state engine: IDLE/PLAY/DEAD machine, per-tick bird and pillar physics,
// LFSR-randomised gap, collision and score. All game outputs are registered.
module flappy_game_engine
   import flappy_pkg::*;
#(
   parameter int TICK_DIV = 200000,
   parameter int GAP_MIN  = 40,
   parameter int FLAP_UP  = 6,
   parameter int FALL_DN  = 4,
   parameter int Y_MIN    = 10,
   parameter int Y_FLOOR  = 455
) (
   input  logic                 dclk,
   input  logic                 clr,
   flappy_game_engine_if.slave  bus
);

   localparam logic [9:0]  BIRD_Y_HOME = 10'd240;
   localparam logic [11:0] PILLAR_HOME = 12'(SCREEN_W);
   localparam logic [7:0]  LFSR_SEED   = 8'hA5;
   localparam logic [9:0]  GAP_Y_HOME  = 10'(GAP_MIN) + {2'b00, LFSR_SEED};

   game_state_t state_r, state_nx_s;

   logic [9:0]  bird_y_r,   bird_y_nx_s;
   logic [11:0] pillar_x_r, pillar_x_nx_s;
   logic [9:0]  gap_y_r,    gap_y_nx_s;
   logic [7:0]  score_r,    score_nx_s;
   logic        gamestate_r;
   logic        game_over_r;
   logic [7:0]  lfsr_r;
   logic        flap_q_r;

   logic        tick_s;
   logic        flap_rise_s;
   logic        start_s;
   logic [11:0] bird_w_s;
   logic [11:0] gap_w_s;
   logic [11:0] bird_move_s;
   logic        x_ov_s;
   logic        y_out_s;
   logic        floor_s;
   logic        hit_s;
   logic        pass_s;

   flappy_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (dclk),
      .clr   (clr),
      .pause (bus.pause),
      .tick  (tick_s)
   );

   assign flap_rise_s = bus.flap & ~flap_q_r;
   assign start_s     = flap_rise_s & ~bus.pause;

   // All geometry is compared in 12-bit unsigned, using the pre-update positions
   assign bird_w_s = {2'b00, bird_y_r};
   assign gap_w_s  = {2'b00, gap_y_r};
   assign x_ov_s   = (pillar_x_r < 12'(BIRD_X + BIRD_SZ)) &&
                     ((pillar_x_r + 12'(PILLAR_W)) > 12'(BIRD_X));
   assign y_out_s  = (bird_w_s < gap_w_s) ||
                     ((bird_w_s + 12'(BIRD_SZ)) > (gap_w_s + 12'(GAP_H)));
   assign floor_s  = (bird_w_s >= 12'(Y_FLOOR));
   assign hit_s    = (x_ov_s & y_out_s) | floor_s;
   assign pass_s   = ((pillar_x_r + 12'(PILLAR_W)) == 12'(BIRD_X));

   // Candidate bird position for a PLAY tick: climb while flapping above Y_MIN, otherwise fall
   always_comb begin
      bird_move_s = bird_w_s + 12'(FALL_DN);
      if (bus.flap && (bird_w_s > 12'(Y_MIN))) begin
         bird_move_s = bird_w_s - 12'(FLAP_UP);
      end else begin
         bird_move_s = bird_w_s + 12'(FALL_DN);
      end
   end

   // Game state register
   always_ff @(posedge dclk) begin
      if (clr) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state and next game values; a colliding tick freezes everything
   always_comb begin
      state_nx_s    = state_r;
      bird_y_nx_s   = bird_y_r;
      pillar_x_nx_s = pillar_x_r;
      gap_y_nx_s    = gap_y_r;
      score_nx_s    = score_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_nx_s = PLAY;
            end else begin
               state_nx_s = IDLE;
            end
         end
         PLAY: begin
            if (!tick_s) begin
               state_nx_s = PLAY;
            end else if (hit_s) begin
               state_nx_s = DEAD;
            end else begin
               state_nx_s  = PLAY;
               bird_y_nx_s = bird_move_s[9:0];
               if (pillar_x_r == 12'd0) begin
                  pillar_x_nx_s = PILLAR_HOME;
                  gap_y_nx_s    = 10'(GAP_MIN) + {2'b00, lfsr_r};
               end else begin
                  pillar_x_nx_s = pillar_x_r - 12'd1;
                  gap_y_nx_s    = gap_y_r;
               end
               if (pass_s && (score_r != 8'hFF)) begin
                  score_nx_s = score_r + 8'd1;
               end else begin
                  score_nx_s = score_r;
               end
            end
         end
         DEAD: begin
            if (start_s) begin
               state_nx_s    = IDLE;
               bird_y_nx_s   = BIRD_Y_HOME;
               pillar_x_nx_s = PILLAR_HOME;
               score_nx_s    = 8'd0;
            end else begin
               state_nx_s = DEAD;
            end
         end
         default: begin
            state_nx_s    = IDLE;
            bird_y_nx_s   = BIRD_Y_HOME;
            pillar_x_nx_s = PILLAR_HOME;
            score_nx_s    = 8'd0;
         end
      endcase
   end

   // Game registers, status flags, flap edge history and gap LFSR
   always_ff @(posedge dclk) begin
      if (clr) begin
         bird_y_r    <= BIRD_Y_HOME;
         pillar_x_r  <= PILLAR_HOME;
         gap_y_r     <= GAP_Y_HOME;
         score_r     <= 8'd0;
         gamestate_r <= 1'b0;
         game_over_r <= 1'b0;
         lfsr_r      <= LFSR_SEED;
         flap_q_r    <= 1'b0;
      end else begin
         bird_y_r    <= bird_y_nx_s;
         pillar_x_r  <= pillar_x_nx_s;
         gap_y_r     <= gap_y_nx_s;
         score_r     <= score_nx_s;
         gamestate_r <= (state_nx_s != IDLE);
         game_over_r <= (state_nx_s == DEAD);
         lfsr_r      <= lfsr_next(lfsr_r);
         flap_q_r    <= bus.flap;
      end
   end

   assign bus.bird_y    = bird_y_r;
   assign bus.pillar_x  = pillar_x_r;
   assign bus.gap_y     = gap_y_r;
   assign bus.score     = score_r;
   assign bus.gamestate = gamestate_r;
   assign bus.game_over = game_over_r;

endmodule
